// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the MIPS bus sequencer: FSM state encoding and
// the default fetch addresses used by the datapath and the sequencer.
package bus_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } seq_state_e;

    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;
    localparam logic [3:0]  BE_WORD      = 4'b1111;

endpackage

// File: rtl/bus_sequencer.sv
// Multi-cycle bus sequencer: fetches an instruction, optionally performs one
// load/store, then pulses clk_enable once so the datapath commits.
module bus_sequencer #(
    parameter logic [31:0] HALT_ADDR    = bus_sequencer_pkg::HALT_ADDR,
    parameter logic [31:0] RESET_VECTOR = bus_sequencer_pkg::RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  byteenable_req,
    output logic [31:0] instr_readdata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic        active,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);
    import bus_sequencer_pkg::*;

    // The datapath PC supplies the reset vector; it only has to be a legal word address.
    if (RESET_VECTOR[1:0] != 2'b00) begin : g_reset_vector_check
        $error("bus_sequencer: RESET_VECTOR must be word-aligned");
    end

    seq_state_e  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] data_q,  data_d;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        data_d     = data_q;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        clk_enable = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (instr_address == HALT_ADDR) begin
                    state_d = HALT;
                end else begin
                    address    = instr_address;
                    read       = 1'b1;
                    byteenable = BE_WORD;
                    if (!waitrequest) begin
                        instr_d = readdata;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (mem_read || mem_write) begin
                    state_d = MEM;
                end else begin
                    clk_enable = 1'b1;
                    state_d    = FETCH;
                end
            end
            MEM: begin
                address    = data_address & WORD_MASK;
                byteenable = byteenable_req;
                // A store takes priority so read and write are never raised together.
                if (mem_write) begin
                    write     = 1'b1;
                    writedata = data_writedata;
                end else if (mem_read) begin
                    read = 1'b1;
                end
                if (!waitrequest) begin
                    if (mem_read && !mem_write) begin
                        data_d = readdata;
                    end
                    state_d = WB;
                end
            end
            WB: begin
                clk_enable = 1'b1;
                state_d    = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset must kill an in-flight request at once, not at the next edge.
        if (reset) begin
            read       = 1'b0;
            write      = 1'b0;
            clk_enable = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
    end

    assign instr_readdata = instr_q;
    assign data_readdata  = data_q;
    assign active         = (state_q != HALT);

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer with a scoreboard of expected bus
// transactions and commits, checked by a negedge monitor.
module tb_bus_sequencer;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address, data_address, data_writedata;
    logic        mem_read, mem_write;
    logic [3:0]  byteenable_req;
    logic [31:0] instr_readdata, data_readdata;
    logic        clk_enable, active;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    bus_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .instr_address  (instr_address),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .byteenable_req (byteenable_req),
        .instr_readdata (instr_readdata),
        .data_readdata  (data_readdata),
        .clk_enable     (clk_enable),
        .active         (active),
        .address        (address),
        .read           (read),
        .write          (write),
        .writedata      (writedata),
        .byteenable     (byteenable),
        .waitrequest    (waitrequest),
        .readdata       (readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] data;
    } commit_t;

    bus_t    bus_q[$];
    commit_t commit_q[$];

    int n_assert  = 0;
    int n_fail    = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int ce_count  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic wr,
                           input logic [31:0] wd);
        bus_t b;
        b.addr = a; b.be = be; b.wr = wr; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic exp_commit(input logic [31:0] instr, input logic [31:0] data);
        commit_t c;
        c.instr = instr; c.data = data;
        commit_q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: accepted bus transfers and commits are matched against the scoreboard.
    always @(negedge clk) begin
        bus_t    b;
        commit_t c;
        if (read)       rd_cycles++;
        if (write)      wr_cycles++;
        if (clk_enable) ce_count++;
        if (read && write) chk("rw_exclusive", 32'(read & write), 32'd0);
        if ((read || write) && !waitrequest) begin
            chk("bus_expected", 32'(bus_q.size() > 0), 32'd1);
            if (bus_q.size() > 0) begin
                b = bus_q.pop_front();
                chk("bus_addr",  address, b.addr);
                chk("bus_be",    32'(byteenable), 32'(b.be));
                chk("bus_write", 32'(write), 32'(b.wr));
                chk("bus_read",  32'(read), 32'(!b.wr));
                if (b.wr) chk("bus_wdata", writedata, b.wdata);
            end
        end
        if (clk_enable) begin
            chk("commit_expected", 32'(commit_q.size() > 0), 32'd1);
            if (commit_q.size() > 0) begin
                c = commit_q.pop_front();
                chk("commit_instr", instr_readdata, c.instr);
                chk("commit_data",  data_readdata,  c.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0, wr0, ce0;
        reset = 1'b1; instr_address = RV; data_address = '0; data_writedata = '0;
        mem_read = 1'b0; mem_write = 1'b0; byteenable_req = '0;
        waitrequest = 1'b0; readdata = '0;
        repeat (2) cyc();
        #1;
        chk("rst_read",       32'(read), 32'd0);
        chk("rst_write",      32'(write), 32'd0);
        chk("rst_clk_enable", 32'(clk_enable), 32'd0);
        chk("rst_active",     32'(active), 32'd1);
        chk("rst_instr",      instr_readdata, 32'd0);
        chk("rst_data",       data_readdata, 32'd0);

        // Zero-wait fetch, no memory op
        readdata = 32'h2402_0005;
        exp_bus(RV, 4'hF, 1'b0, 32'd0);
        exp_commit(32'h2402_0005, 32'd0);
        rd0 = rd_cycles; ce0 = ce_count;
        reset = 1'b0;
        #1;
        chk("s1_read",      32'(read), 32'd1);
        chk("s1_addr",      address, RV);
        chk("s1_be",        32'(byteenable), 32'hF);
        chk("s1_writedata", writedata, 32'd0);
        cyc();
        chk("s1_exec_ce",    32'(clk_enable), 32'd1);
        chk("s1_exec_read",  32'(read), 32'd0);
        chk("s1_exec_instr", instr_readdata, 32'h2402_0005);
        cyc();
        chk("s1_read_cycles", 32'(rd_cycles - rd0), 32'd1);
        chk("s1_ce_count",    32'(ce_count - ce0), 32'd1);

        // Fetch stalled three cycles by waitrequest
        instr_address = RV + 32'd4; readdata = 32'hDEAD_BEEF; waitrequest = 1'b1;
        exp_bus(RV + 32'd4, 4'hF, 1'b0, 32'd0);
        exp_commit(32'h3C01_1234, 32'd0);
        rd0 = rd_cycles; ce0 = ce_count;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s2_hold_addr", address, RV + 32'd4);
            chk("s2_hold_read", 32'(read), 32'd1);
            cyc();
        end
        waitrequest = 1'b0; readdata = 32'h3C01_1234;
        #1;
        chk("s2_accept_read", 32'(read), 32'd1);
        cyc();
        chk("s2_exec_instr", instr_readdata, 32'h3C01_1234);
        chk("s2_exec_ce",    32'(clk_enable), 32'd1);
        cyc();
        chk("s2_read_cycles", 32'(rd_cycles - rd0), 32'd4);
        chk("s2_ce_count",    32'(ce_count - ce0), 32'd1);

        // Load with misaligned address and single byte lane
        instr_address = RV + 32'd8; readdata = 32'h8C82_0006;
        exp_bus(RV + 32'd8, 4'hF, 1'b0, 32'd0);
        exp_bus(32'h0000_1004, 4'b0100, 1'b0, 32'd0);
        exp_commit(32'h8C82_0006, 32'hAABB_CCDD);
        cyc();
        mem_read = 1'b1; data_address = 32'h0000_1006; byteenable_req = 4'b0100;
        #1;
        chk("s3_exec_ce", 32'(clk_enable), 32'd0);
        cyc();
        readdata = 32'hAABB_CCDD;
        #1;
        chk("s3_mem_addr",  address, 32'h0000_1004);
        chk("s3_mem_be",    32'(byteenable), 32'b0100);
        chk("s3_mem_read",  32'(read), 32'd1);
        chk("s3_mem_write", 32'(write), 32'd0);
        chk("s3_mem_instr", instr_readdata, 32'h8C82_0006);
        cyc();
        chk("s3_wb_ce",    32'(clk_enable), 32'd1);
        chk("s3_wb_read",  32'(read), 32'd0);
        chk("s3_wb_data",  data_readdata, 32'hAABB_CCDD);
        chk("s3_wb_instr", instr_readdata, 32'h8C82_0006);
        cyc();
        mem_read = 1'b0;

        // Store held by waitrequest for two cycles
        instr_address = RV + 32'd12; readdata = 32'hAC43_0000;
        exp_bus(RV + 32'd12, 4'hF, 1'b0, 32'd0);
        exp_bus(32'h0000_2000, 4'hF, 1'b1, 32'h1234_5678);
        exp_commit(32'hAC43_0000, 32'hAABB_CCDD);
        cyc();
        mem_write = 1'b1; data_address = 32'h0000_2003; data_writedata = 32'h1234_5678;
        byteenable_req = 4'hF; waitrequest = 1'b1; readdata = 32'h5555_5555;
        wr0 = wr_cycles;
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("s4_hold_write", 32'(write), 32'd1);
            chk("s4_hold_read",  32'(read), 32'd0);
            chk("s4_hold_wdata", writedata, 32'h1234_5678);
            chk("s4_hold_addr",  address, 32'h0000_2000);
            cyc();
        end
        waitrequest = 1'b0;
        #1;
        chk("s4_accept_write", 32'(write), 32'd1);
        cyc();
        chk("s4_wb_ce",    32'(clk_enable), 32'd1);
        chk("s4_wb_write", 32'(write), 32'd0);
        chk("s4_wb_data",  data_readdata, 32'hAABB_CCDD);
        chk("s4_write_cycles", 32'(wr_cycles - wr0), 32'd3);
        cyc();
        mem_write = 1'b0;

        // PC reaches the halt address
        instr_address = 32'h0000_0000;
        rd0 = rd_cycles; ce0 = ce_count;
        #1;
        chk("s5_no_read", 32'(read), 32'd0);
        cyc();
        chk("s5_active",     32'(active), 32'd0);
        chk("s5_read",       32'(read), 32'd0);
        chk("s5_write",      32'(write), 32'd0);
        chk("s5_clk_enable", 32'(clk_enable), 32'd0);
        instr_address = RV;
        repeat (4) cyc();
        chk("s5_absorb_active", 32'(active), 32'd0);
        chk("s5_absorb_read",   32'(read), 32'd0);
        chk("s5_read_cycles",   32'(rd_cycles - rd0), 32'd0);
        chk("s5_ce_count",      32'(ce_count - ce0), 32'd0);

        // Reset asserted mid-store
        reset = 1'b1;
        #1;
        chk("s6_rst_active", 32'(active), 32'd1);
        chk("s6_rst_read",   32'(read), 32'd0);
        cyc();
        instr_address = RV + 32'h10; readdata = 32'hAC00_0000;
        exp_bus(RV + 32'h10, 4'hF, 1'b0, 32'd0);
        reset = 1'b0;
        #1;
        chk("s6_fetch_read", 32'(read), 32'd1);
        cyc();
        mem_write = 1'b1; data_address = 32'h0000_3000; data_writedata = 32'hCAFE_F00D;
        byteenable_req = 4'hF; waitrequest = 1'b1;
        cyc();
        #1;
        chk("s6_mem_write", 32'(write), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("s6_async_write",  32'(write), 32'd0);
        chk("s6_async_read",   32'(read), 32'd0);
        chk("s6_async_active", 32'(active), 32'd1);
        chk("s6_async_instr",  instr_readdata, 32'd0);
        cyc();
        mem_write = 1'b0; waitrequest = 1'b0;
        instr_address = RV; readdata = 32'h2402_0005;
        exp_bus(RV, 4'hF, 1'b0, 32'd0);
        exp_commit(32'h2402_0005, 32'd0);
        ce0 = ce_count;
        reset = 1'b0;
        #1;
        chk("s6_restart_read",   32'(read), 32'd1);
        chk("s6_restart_active", 32'(active), 32'd1);
        cyc();
        chk("s6_restart_ce", 32'(clk_enable), 32'd1);
        cyc();
        chk("s6_ce_count",     32'(ce_count - ce0), 32'd1);
        chk("bus_q_drained",   32'(bus_q.size()), 32'd0);
        chk("commit_q_drained", 32'(commit_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
- HALT_ADDR, 32'h0000_0000, fetch address that ends execution.
- RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset (informational; the datapath PC supplies it).

REQ-002 The block SHALL expose these ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock.
- reset, input, 1, asynchronous active-high reset.
- instr_address, input, 32, PC from the datapath.
- data_address, input, 32, ALU result used as the load/store address.
- data_writedata, input, 32, store data from the register file.
- mem_read, input, 1, decoded load.
- mem_write, input, 1, decoded store.
- byteenable_req, input, 4, decoded byte lanes for the load/store.
- instr_readdata, output, 32, latched instruction register.
- data_readdata, output, 32, latched load data.
- clk_enable, output, 1, one-cycle commit strobe to the datapath.
- active, output, 1, high while the CPU runs.
- address, output, 32, bus address.
- read, output, 1, bus read request.
- write, output, 1, bus write request.
- writedata, output, 32, bus write data.
- byteenable, output, 4, bus byte lanes.
- waitrequest, input, 1, bus stall.
- readdata, input, 32, bus read data.

Function
REQ-003 The block SHALL implement FSM states FETCH, EXEC, MEM, WB and HALT.
REQ-004 In FETCH it SHALL drive address=instr_address, read=1, write=0, byteenable=4'b1111.
REQ-005 FETCH SHALL hold all bus outputs stable while waitrequest=1.
REQ-006 In the first FETCH cycle with waitrequest=0, the block SHALL latch readdata into instr_readdata and go to EXEC.
REQ-007 EXEC SHALL drive read=0 and write=0.
REQ-008 EXEC SHALL go to MEM if mem_read or mem_write is high; otherwise it SHALL assert clk_enable for that cycle and go to FETCH.
REQ-009 MEM SHALL drive address={data_address[31:2],2'b00} and byteenable=byteenable_req.
REQ-010 MEM SHALL drive write=1 with writedata=data_writedata for stores, or read=1 for loads.
REQ-011 If mem_read and mem_write are both high, write SHALL win and read SHALL stay 0.
REQ-012 MEM SHALL hold its outputs while waitrequest=1.
REQ-013 When waitrequest=0 in MEM, the block SHALL latch readdata into data_readdata (loads only; unchanged on stores) and go to WB.
REQ-014 WB SHALL assert clk_enable for exactly one cycle with no bus request and go to FETCH.
REQ-015 clk_enable SHALL be 0 in FETCH, MEM and HALT; latency is one commit per instruction, minimum 2 cycles for non-memory instructions and 4 for memory instructions.
REQ-016 On entering FETCH, if instr_address==HALT_ADDR, the block SHALL go to HALT instead of issuing a read.
REQ-017 HALT SHALL be absorbing until reset; in HALT, active=0, read=0, write=0 and clk_enable=0.
REQ-018 read and write SHALL never be high in the same cycle.
REQ-019 An unbounded waitrequest SHALL stall the FSM indefinitely without error.
REQ-020 instr_readdata SHALL hold constant from EXEC through the end of WB.

Reset
REQ-021 reset SHALL immediately force state=FETCH, read=0, write=0, clk_enable=0, instr_readdata=0, data_readdata=0 and active=1, including in the middle of a bus transaction.
REQ-022 The first FETCH read SHALL issue in the first clk edge after reset deasserts, with byteenable=4'b1111, address=instr_address and writedata=0 in that cycle.

Structure
REQ-023 The state enum, HALT_ADDR and RESET_VECTOR SHALL live in the shared mips package.
REQ-024 The block SHALL be a single module with no sub-modules; the instruction and data latches SHALL be inline enabled registers.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Zero-wait fetch at instr_address=BFC00000, readdata=24020005, no memory op -> read high 1 cycle, instr_readdata=24020005, clk_enable pulses on the 2nd cycle.
- Fetch with waitrequest high for 3 cycles -> address and read stable for 4 cycles, then latch; clk_enable exactly 1 pulse.
- Load: mem_read=1, data_address=00001006, byteenable_req=0100, readdata=AABBCCDD -> address=00001004, byteenable=0100, data_readdata=AABBCCDD, clk_enable pulse in WB.
- Store: mem_write=1, data_writedata=12345678, waitrequest high 2 cycles -> write held 3 cycles, writedata=12345678, read=0 throughout.
- Datapath PC becomes 00000000 after a commit -> no read issued, active falls to 0, no further clk_enable.
- reset asserted mid-MEM with write=1 -> write drops without waiting for clk; after release, FETCH restarts and active=1.
